icache_refill_bridge: RTL and testbench

- MMU-side responder for the instruction-cache line-refill interface.
- Accepts one line-read request from the I-cache and completes the address handshake (inst_addr_ok).
- Issues a single AXI4 INCR burst read of BURST_LEN 32-bit words.
- Returns each beat to the I-cache with mmu_valid; the final beat is flagged with mmu_last.

---
 rtl/cpu_axi_pkg.sv | 14 +
 rtl/icache_refill_bridge.sv | 95 +++++++++
 tb/tb_icache_refill_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared AXI encodings and refill FSM state type
package cpu_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } refill_state_t;

endpackage

// File: rtl/icache_refill_bridge.sv
// rtl/icache_refill_bridge.sv - I-cache line refill to single AXI4 INCR burst read
module icache_refill_bridge
    import cpu_axi_pkg::*;
#(
    parameter int         BURST_LEN = 16,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_mmu,
    input  logic        inst_read_req,
    output logic        inst_addr_ok,
    output logic [31:0] inst_read_data,
    output logic        mmu_valid,
    output logic        mmu_last,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_error
);

    localparam int                CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    refill_state_t    state;
    refill_state_t    state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat_acc;
    logic             beat_bad;

    // rid is never checked and the low line-offset bits are discarded
    logic unused_bits;
    assign unused_bits = ^{rid, inst_addr_mmu[5:0]};

    assign beat_acc = (state == DATA) && rvalid;
    assign beat_bad = (rlast && (beat_cnt != LAST_BEAT))
                   || (!rlast && (beat_cnt == LAST_BEAT))
                   || (rresp != AXI_RESP_OKAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            araddr    <= 32'd0;
            beat_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && inst_read_req) begin
                araddr   <= {inst_addr_mmu[31:6], 6'b0};
                beat_cnt <= '0;
            end
            if (beat_acc) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_bad) begin
                    bus_error <= 1'b1;
                end
            end
        end
    end

    // The burst only ever ends on rlast, even when the beat count disagrees
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inst_read_req)   state_next = ADDR;
            ADDR:    if (arready)         state_next = DATA;
            DATA:    if (rvalid && rlast) state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        arid           = AXI_ID;
        arlen          = 8'(BURST_LEN - 1);
        arsize         = AXI_SIZE_4B;
        arburst        = AXI_BURST_INCR;
        arvalid        = (state == ADDR);
        inst_addr_ok   = (state == ADDR) && arready;
        rready         = (state == DATA);
        inst_read_data = rdata;
        mmu_valid      = beat_acc;
        mmu_last       = beat_acc && rlast;
    end

endmodule

// File: tb/tb_icache_refill_bridge.sv
// tb/tb_icache_refill_bridge.sv - directed self-checking bench for icache_refill_bridge
module tb_icache_refill_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_mmu;
    logic        inst_read_req;
    logic        inst_addr_ok;
    logic [31:0] inst_read_data;
    logic        mmu_valid;
    logic        mmu_last;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_refill_bridge #(.BURST_LEN(16), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .inst_addr_mmu(inst_addr_mmu), .inst_read_req(inst_read_req),
        .inst_addr_ok(inst_addr_ok), .inst_read_data(inst_read_data),
        .mmu_valid(mmu_valid), .mmu_last(mmu_last),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .bus_error(bus_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All tasks enter and leave aligned to a falling clock edge.
    task automatic req_line(input logic [31:0] addr, input int stall);
        inst_read_req = 1'b1;
        inst_addr_mmu = addr;
        arready       = 1'b0;
        #1 check("ok_in_idle", inst_addr_ok, 0);
        check("arvalid_in_idle", arvalid, 0);
        @(negedge clk);
        inst_read_req = 1'b0;
        inst_addr_mmu = 32'hDEAD_BEEF;
        for (int i = 0; i < stall; i++) begin
            #1 check("stall_arvalid", arvalid, 1);
            check("stall_araddr", araddr, {addr[31:6], 6'b0});
            check("stall_ok", inst_addr_ok, 0);
            @(negedge clk);
        end
        arready = 1'b1;
        #1 check("ar_ok", inst_addr_ok, 1);
        check("ar_valid", arvalid, 1);
        check("ar_addr", araddr, {addr[31:6], 6'b0});
        check("ar_len", arlen, 15);
        check("ar_size", arsize, 2);
        check("ar_burst", arburst, 1);
        check("ar_id", arid, 0);
        @(negedge clk);
        arready = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last, input logic [1:0] resp);
        rvalid = 1'b1;
        rdata  = data;
        rlast  = last;
        rresp  = resp;
        #1 check("beat_valid", mmu_valid, 1);
        check("beat_data", inst_read_data, data);
        check("beat_last", mmu_last, last);
        check("beat_rready", rready, 1);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic gap_cycle();
        rvalid = 1'b0;
        rlast  = 1'b1;
        rdata  = 32'hFFFF_FFFF;
        #1 check("gap_valid", mmu_valid, 0);
        check("gap_last", mmu_last, 0);
        @(negedge clk);
        rlast = 1'b0;
    endtask

    task automatic burst(input logic [31:0] base, input int n, input int last_idx, input int bad_idx);
        for (int i = 0; i < n; i++)
            send_beat(base + 32'(i), i == last_idx, (i == bad_idx) ? 2'b10 : 2'b00);
    endtask

    task automatic idle_check(input string tag, input logic exp_err);
        #1 check({tag, "_rready"}, rready, 0);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_bus_error"}, bus_error, exp_err);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst_addr_mmu = 0; inst_read_req = 0; arready = 0;
        rid = 4'h5; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        #1 check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_ok", inst_addr_ok, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_araddr", araddr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // basic refill
        req_line(32'h1FC0_0044, 0);
        burst(32'd0, 16, 15, -1);
        idle_check("basic", 0);

        // AR backpressure
        req_line(32'h8000_1234, 5);
        burst(32'h100, 16, 15, -1);
        idle_check("bp", 0);

        // R gaps: two idle cycles after every even beat
        req_line(32'h0000_0FC0, 0);
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h200 + 32'(i), i == 15, 2'b00);
            check("gap_beat_cnt", 32'(dut.beat_cnt), 32'((i + 1) % 16));
            if ((i % 2 == 0) && (i != 15)) begin
                gap_cycle();
                gap_cycle();
            end
        end
        idle_check("gaps", 0);

        // bad response on beat 3, sticky through a clean burst
        req_line(32'h0000_1000, 0);
        burst(32'h300, 16, 15, 2);
        idle_check("badresp", 1);
        req_line(32'h0000_1040, 0);
        burst(32'h400, 16, 15, -1);
        idle_check("sticky", 1);

        // async reset at beat 5
        req_line(32'h0000_2000, 0);
        burst(32'h500, 4, -1, -1);
        rvalid = 1'b1; rdata = 32'h504;
        #1 check("pre_rst_valid", mmu_valid, 1);
        #1 rst = 1'b1;
        #1 check("async_arvalid", arvalid, 0);
        check("async_rready", rready, 0);
        check("async_valid", mmu_valid, 0);
        check("async_bus_error", bus_error, 0);
        check("async_araddr", araddr, 0);
        @(negedge clk);
        rvalid = 1'b0; rst = 1'b0;
        @(negedge clk);
        req_line(32'h0000_3000, 0);
        burst(32'h600, 16, 15, -1);
        idle_check("after_rst", 0);

        // early rlast on beat 8, then a normal request
        req_line(32'h0000_4000, 0);
        burst(32'h700, 8, 7, -1);
        idle_check("early", 1);
        req_line(32'h0000_4080, 0);
        burst(32'h800, 16, 15, -1);
        idle_check("early_next", 1);

        // missing rlast on beat 16, burst ends on beat 17
        pulse_reset();
        #1 check("rst2_bus_error", bus_error, 0);
        @(negedge clk);
        req_line(32'h0000_5000, 0);
        burst(32'h900, 16, -1, -1);
        #1 check("nolast_bus_error", bus_error, 1);
        check("nolast_rready", rready, 1);
        @(negedge clk);
        send_beat(32'h910, 1'b1, 2'b00);
        idle_check("nolast", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
